second_stage_window_scheduler: RTL and testbench
================================================

// Module: second_stage_window_scheduler
// PURPOSE
//  Shares the second-stage integral-image FIFO between N_REQ first-stage candidate sources.
//  Write side: round-robin arbitration, then streams one whole WIN=INTEGRAL_WIDTH*INTEGRAL_HEIGHT-word
//  window from the granted source into the FIFO.
//  Read side: pops complete windows in bursts to the second-stage compute unit when it is ready.
//  Sits between the first-stage classifiers and the FIFO/compute pair of the second stage.
// PARAMETERS
//  N_REQ           4     number of candidate-window sources
//  ADDR_WIDTH      10    FIFO usedw width
//  FIFO_DEPTH      1020  usable FIFO words (<= 2**ADDR_WIDTH-1)
//  DATA_WIDTH_8    8     counter / index width
//  DATA_WIDTH_12   12    integral-image word width
//  INTEGRAL_WIDTH  3     window width; INTEGRAL_HEIGHT 3 window height (WIN = 9 words)
// PORTS
//  clk_fpga        in   1                    system clock, all logic on rising edge
//  reset_fpga      in   1                    asynchronous, active-low reset
//  i_req           in   N_REQ                source k has a full window ready (level)
//  i_data          in   N_REQ*DATA_WIDTH_12  flattened source words; source k presents word o_word_idx
//  o_grant         out  N_REQ                one-hot, held for the whole transfer
//  o_word_idx      out  DATA_WIDTH_8         window element index requested from the granted source
//  o_fifo_sclr     out  1                    FIFO flush pulse
//  o_fifo_wrreq    out  1                    FIFO write strobe
//  o_fifo_data     out  DATA_WIDTH_12        FIFO write data
//  i_fifo_usedw    in   ADDR_WIDTH           FIFO fill level (updates 1 cycle after wr/rd)
//  o_fifo_rdreq    out  1                    FIFO read strobe (normal mode, q valid next cycle)
//  i_fifo_q        in   DATA_WIDTH_12        FIFO read data
//  i_compute_ready in   1                    compute unit can accept a new window
//  o_win_data      out  DATA_WIDTH_12        window word to compute unit
//  o_win_valid     out  1                    o_win_data valid
//  o_win_last      out  1                    marks word WIN-1 of a window
//  o_win_count     out  DATA_WIDTH_8         complete windows held in FIFO
// BEHAVIOUR
//  Reset (reset_fpga=0): all outputs 0 except o_fifo_sclr=1; rr pointer=0; both FSMs idle;
//   o_fifo_sclr deasserts at the first clk_fpga edge after release (one-cycle flush).
//   Reset mid-transfer aborts both sides; the flush discards the partial window.
//  Write FSM W_IDLE -> W_XFER -> W_IDLE:
//   W_IDLE: if |i_req and (FIFO_DEPTH - i_fifo_usedw) >= WIN+1 (margin covers usedw lag)
//    and not o_fifo_sclr: grant first requesting source at/after rr pointer; o_grant registered; go W_XFER.
//   W_XFER: o_fifo_wrreq=1 for exactly WIN consecutive cycles, o_word_idx 0..WIN-1;
//    o_fifo_data = i_data slice of the granted source at o_word_idx (combinational mux).
//    After word WIN-1: o_grant clears, rr pointer = granted+1 mod N_REQ, return to W_IDLE.
//   Dropping i_req during W_XFER does not abort; the window completes.
//   Minimum gap of 1 idle cycle between windows; no grant while space is insufficient (stall, no drop).
//  Read FSM R_IDLE -> R_BURST -> R_IDLE:
//   R_IDLE: if o_win_count > 0 and i_compute_ready: go R_BURST.
//   R_BURST: o_fifo_rdreq=1 for exactly WIN cycles; i_compute_ready is ignored once the burst starts.
//   o_win_valid = o_fifo_rdreq delayed 1 cycle; o_win_data = i_fifo_q; o_win_last on the WIN-th valid.
//  o_win_count: +1 on the write of word WIN-1; -1 on R_IDLE->R_BURST;
//   both in the same cycle -> unchanged. Saturates at 255, never underflows.
//   Partial windows are never counted, so a read cannot overtake a write in progress.
//  Widths: o_word_idx and read counters are DATA_WIDTH_8 and wrap to 0 after WIN-1.
// STRUCTURE
//  Shared package second_stage_pkg: localparam WIN, write-state encodings (W_IDLE, W_XFER),
//   read-state encodings (R_IDLE, R_BURST).
//  Sub-module rr_arbiter (N_REQ, request vector + pointer -> one-hot grant);
//   remaining FSMs and counters are inline.
// TESTING
//  1 Reset release: o_fifo_sclr=1 for 1 cycle, all other outputs 0, o_win_count=0.
//  2 Single source i_req=4'b0100, usedw=0 -> o_grant=0100, 9 wrreq cycles with idx 0..8,
//    data matches source 2; o_win_count=1.
//  3 All four i_req held -> grants 0001,0010,0100,1000,0001 in order, one idle cycle between windows.
//  4 usedw=1011 (free=9 < 10) with i_req -> no grant; usedw drops to 1010 -> grant next cycle.
//  5 o_win_count=1, i_compute_ready=1 -> 9 rdreq, o_win_valid 1 cycle later for 9 cycles,
//    o_win_last on the 9th; a write ending on the burst-start cycle leaves count=1.
//  6 Assert reset_fpga=0 at word 4 of a transfer -> outputs clear immediately;
//    after release o_fifo_sclr pulses and arbitration restarts from source 0.

Source files
------------

// File: rtl/second_stage_pkg.sv
// Shared types and constants for the second-stage window scheduler.
package second_stage_pkg;

    // Default window geometry. WIN is the number of words in one integral-image window.
    localparam int DEF_INTEGRAL_WIDTH  = 3;
    localparam int DEF_INTEGRAL_HEIGHT = 3;
    localparam int WIN                 = DEF_INTEGRAL_WIDTH * DEF_INTEGRAL_HEIGHT;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_XFER = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } rd_state_t;

    // Index of the lowest set bit. A one-hot vector maps to its position; zero maps to 0.
    function automatic int unsigned onehot_idx(input logic [31:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/second_stage_window_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    int   cand;
    logic found;

    // Scan requesters starting at the pointer, wrapping around; the first hit wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (int'(ptr) + i) % N_REQ;
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/second_stage_window_scheduler.sv
// Shares the second-stage integral-image FIFO between N_REQ candidate sources:
// round-robin window writes on one side, whole-window read bursts on the other.
module second_stage_window_scheduler
    import second_stage_pkg::*;
#(
    parameter int N_REQ           = 4,
    parameter int ADDR_WIDTH      = 10,
    parameter int FIFO_DEPTH      = 1020,
    parameter int DATA_WIDTH_8    = 8,
    parameter int DATA_WIDTH_12   = 12,
    parameter int INTEGRAL_WIDTH  = DEF_INTEGRAL_WIDTH,
    parameter int INTEGRAL_HEIGHT = DEF_INTEGRAL_HEIGHT
) (
    input  logic                           clk_fpga,
    input  logic                           reset_fpga,
    input  logic [N_REQ-1:0]               i_req,
    input  logic [N_REQ*DATA_WIDTH_12-1:0] i_data,
    output logic [N_REQ-1:0]               o_grant,
    output logic [DATA_WIDTH_8-1:0]        o_word_idx,
    output logic                           o_fifo_sclr,
    output logic                           o_fifo_wrreq,
    output logic [DATA_WIDTH_12-1:0]       o_fifo_data,
    input  logic [ADDR_WIDTH-1:0]          i_fifo_usedw,
    output logic                           o_fifo_rdreq,
    input  logic [DATA_WIDTH_12-1:0]       i_fifo_q,
    input  logic                           i_compute_ready,
    output logic [DATA_WIDTH_12-1:0]       o_win_data,
    output logic                           o_win_valid,
    output logic                           o_win_last,
    output logic [DATA_WIDTH_8-1:0]        o_win_count
);

    localparam int WIN_LEN = INTEGRAL_WIDTH * INTEGRAL_HEIGHT;
    localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [DATA_WIDTH_8-1:0] LAST_IDX = DATA_WIDTH_8'(WIN_LEN - 1);
    localparam logic [DATA_WIDTH_8-1:0] CNT_MAX  = '1;

    wr_state_t                 wr_state, wr_state_nxt;
    rd_state_t                 rd_state, rd_state_nxt;
    logic [N_REQ-1:0]          grant_q, arb_grant;
    logic [PTR_W-1:0]          rr_ptr;
    logic [DATA_WIDTH_8-1:0]   word_idx, rd_idx, win_count;
    logic                      sclr_q, win_valid_q, win_last_q;
    logic                      space_ok, wr_start, wr_done, rd_start, rd_done;
    logic                      wrreq, rdreq;
    int                        free_words;
    int unsigned               gidx;

    rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
        .req   (i_req),
        .ptr   (rr_ptr),
        .grant (arb_grant)
    );

    // Free space check; the extra word of margin absorbs the one-cycle usedw lag.
    always_comb begin
        free_words = FIFO_DEPTH - int'(i_fifo_usedw);
        space_ok   = free_words >= (WIN_LEN + 1);
        gidx       = onehot_idx(32'(grant_q));
    end

    assign wr_start = (wr_state == W_IDLE) && (|i_req) && space_ok && !sclr_q;
    assign wr_done  = (wr_state == W_XFER) && (word_idx == LAST_IDX);
    // Only complete windows are counted, so a burst never reads a window still being written.
    assign rd_start = (rd_state == R_IDLE) && (win_count != '0) && i_compute_ready;
    assign rd_done  = (rd_state == R_BURST) && (rd_idx == LAST_IDX);

    // Write FSM state register.
    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) wr_state <= W_IDLE;
        else             wr_state <= wr_state_nxt;
    end

    // Write FSM next state: one whole window per grant, then back to idle for a cycle.
    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            W_IDLE:  if (wr_start) wr_state_nxt = W_XFER;
            W_XFER:  if (wr_done)  wr_state_nxt = W_IDLE;
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    // Write FSM outputs.
    always_comb begin
        wrreq = (wr_state == W_XFER);
    end

    // Grant, word index and round-robin pointer for the window being written.
    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            grant_q  <= '0;
            word_idx <= '0;
            rr_ptr   <= '0;
        end else if (wr_start) begin
            grant_q  <= arb_grant;
            word_idx <= '0;
        end else if (wr_done) begin
            grant_q  <= '0;
            word_idx <= '0;
            rr_ptr   <= PTR_W'((gidx + 1) % N_REQ);
        end else if (wrreq) begin
            word_idx <= word_idx + 1'b1;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) rd_state <= R_IDLE;
        else             rd_state <= rd_state_nxt;
    end

    // Read FSM next state: once started, a burst runs to completion regardless of ready.
    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            R_IDLE:  if (rd_start) rd_state_nxt = R_BURST;
            R_BURST: if (rd_done)  rd_state_nxt = R_IDLE;
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        rdreq = (rd_state == R_BURST);
    end

    // Word counter inside a read burst.
    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga)   rd_idx <= '0;
        else if (rd_start) rd_idx <= '0;
        else if (rd_done)  rd_idx <= '0;
        else if (rdreq)    rd_idx <= rd_idx + 1'b1;
    end

    // Complete-window count: up on the last written word, down when a burst claims a window.
    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            win_count <= '0;
        end else if (wr_done && !rd_start) begin
            if (win_count != CNT_MAX) win_count <= win_count + 1'b1;
        end else if (rd_start && !wr_done) begin
            win_count <= win_count - 1'b1;
        end
    end

    // One-cycle FIFO flush after reset release.
    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) sclr_q <= 1'b1;
        else             sclr_q <= 1'b0;
    end

    // FIFO q is valid the cycle after rdreq, so valid/last follow the read strobe by one cycle.
    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            win_valid_q <= rdreq;
            win_last_q  <= rd_done;
        end
    end

    // Output mapping; data buses are forced to zero when not qualified.
    always_comb begin
        o_grant      = grant_q;
        o_word_idx   = word_idx;
        o_fifo_sclr  = sclr_q;
        o_fifo_wrreq = wrreq;
        o_fifo_data  = wrreq ? i_data[gidx*DATA_WIDTH_12 +: DATA_WIDTH_12] : '0;
        o_fifo_rdreq = rdreq;
        o_win_valid  = win_valid_q;
        o_win_last   = win_last_q;
        o_win_data   = win_valid_q ? i_fifo_q : '0;
        o_win_count  = win_count;
    end

endmodule

// File: tb/tb_second_stage_window_scheduler.sv
// Self-checking bench for second_stage_window_scheduler with a behavioural FIFO
// and a scoreboard of expected window words.
module tb_second_stage_window_scheduler;

    localparam int N   = 4;
    localparam int DW  = 12;
    localparam int WN  = 9;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    i_req = '0;
    logic [N*DW-1:0] i_data;
    logic [N-1:0]    o_grant;
    logic [7:0]      o_word_idx;
    logic            o_fifo_sclr, o_fifo_wrreq, o_fifo_rdreq;
    logic [DW-1:0]   o_fifo_data, fifo_q, o_win_data;
    logic [9:0]      i_fifo_usedw, model_usedw, ovr_val;
    logic            ovr_en = 1'b0;
    logic            i_compute_ready = 1'b0;
    logic            o_win_valid, o_win_last;
    logic [7:0]      o_win_count;

    int n_assert = 0;
    int n_fail   = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    second_stage_window_scheduler dut (
        .clk_fpga(clk), .reset_fpga(rst_n), .i_req(i_req), .i_data(i_data),
        .o_grant(o_grant), .o_word_idx(o_word_idx), .o_fifo_sclr(o_fifo_sclr),
        .o_fifo_wrreq(o_fifo_wrreq), .o_fifo_data(o_fifo_data), .i_fifo_usedw(i_fifo_usedw),
        .o_fifo_rdreq(o_fifo_rdreq), .i_fifo_q(fifo_q), .i_compute_ready(i_compute_ready),
        .o_win_data(o_win_data), .o_win_valid(o_win_valid), .o_win_last(o_win_last),
        .o_win_count(o_win_count)
    );

    function automatic logic [DW-1:0] src_word(input int k, input int idx);
        return DW'((k + 1) * 300 + idx * 7 + 5);
    endfunction

    // Each source presents the word selected by o_word_idx.
    always_comb begin
        i_data = '0;
        for (int k = 0; k < N; k++) i_data[k*DW +: DW] = src_word(k, int'(o_word_idx));
    end

    // Behavioural normal-mode FIFO: q updates the cycle after rdreq, usedw lags by one cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            fifo_q      <= '0;
            model_usedw <= '0;
        end else if (o_fifo_sclr) begin
            fq.delete();
            model_usedw <= '0;
        end else begin
            if (o_fifo_wrreq) fq.push_back(o_fifo_data);
            if (o_fifo_rdreq && fq.size() > 0) fifo_q <= fq.pop_front();
            model_usedw <= 10'(fq.size());
        end
    end
    assign i_fifo_usedw = ovr_en ? ovr_val : model_usedw;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_assert++;
        if (o_fifo_sclr !== 1'b1) begin n_fail++; $display("FAIL reset_sclr got %b exp 1", o_fifo_sclr); end
        n_assert++;
        if ({o_grant, o_word_idx, o_fifo_wrreq, o_fifo_data, o_fifo_rdreq} !== '0) begin
            n_fail++; $display("FAIL reset_wr_outputs got %b %0d %b %h %b exp zeros",
                               o_grant, o_word_idx, o_fifo_wrreq, o_fifo_data, o_fifo_rdreq);
        end
        n_assert++;
        if ({o_win_data, o_win_valid, o_win_last, o_win_count} !== '0) begin
            n_fail++; $display("FAIL reset_rd_outputs got %h %b %b %0d exp zeros",
                               o_win_data, o_win_valid, o_win_last, o_win_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_assert++;
        if (o_fifo_sclr !== 1'b1) begin n_fail++; $display("FAIL sclr_before_edge got %b exp 1", o_fifo_sclr); end
        @(negedge clk);
        n_assert++;
        if (o_fifo_sclr !== 1'b0) begin n_fail++; $display("FAIL sclr_after_edge got %b exp 0", o_fifo_sclr); end
        @(negedge clk);
        n_assert++;
        if (o_fifo_sclr !== 1'b0 || o_win_count !== 8'd0) begin
            n_fail++; $display("FAIL sclr_one_cycle got sclr=%b cnt=%0d exp 0 0", o_fifo_sclr, o_win_count);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] eg;
        i_req = 4'b1111;
        @(negedge clk);
        for (int w = 0; w < 5; w++) begin
            eg = 4'(1 << (w % 4));
            for (int i = 0; i < WN; i++) begin
                n_assert++;
                if (o_grant !== eg || o_fifo_wrreq !== 1'b1 || o_word_idx !== 8'(i)) begin
                    n_fail++; $display("FAIL rr_xfer w=%0d i=%0d got g=%b wr=%b idx=%0d exp g=%b wr=1 idx=%0d",
                                       w, i, o_grant, o_fifo_wrreq, o_word_idx, eg, i);
                end
                n_assert++;
                if (o_fifo_data !== src_word(w % 4, i)) begin
                    n_fail++; $display("FAIL rr_data w=%0d i=%0d got %h exp %h", w, i, o_fifo_data, src_word(w % 4, i));
                end
                exp_q.push_back(src_word(w % 4, i));
                @(negedge clk);
            end
            n_assert++;
            if (o_grant !== '0 || o_fifo_wrreq !== 1'b0) begin
                n_fail++; $display("FAIL rr_gap w=%0d got g=%b wr=%b exp 0 0", w, o_grant, o_fifo_wrreq);
            end
            if (w == 4) i_req = '0;
            @(negedge clk);
        end
        n_assert++;
        if (o_win_count !== 8'd5) begin n_fail++; $display("FAIL rr_count got %0d exp 5", o_win_count); end
    endtask

    task automatic test_drain(input int n_win);
        int beats = 0;
        int cyc = 0;
        logic [DW-1:0] e;
        i_compute_ready = 1'b1;
        while (beats < n_win * WN && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (o_win_valid) begin
                n_assert++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL drain_extra got %h exp none", o_win_data);
                end else begin
                    e = exp_q.pop_front();
                    if (o_win_data !== e) begin n_fail++; $display("FAIL drain_data beat=%0d got %h exp %h", beats, o_win_data, e); end
                end
                n_assert++;
                if (o_win_last !== ((beats % WN) == WN - 1)) begin
                    n_fail++; $display("FAIL drain_last beat=%0d got %b exp %b", beats, o_win_last, (beats % WN) == WN - 1);
                end
                beats++;
            end
        end
        i_compute_ready = 1'b0;
        n_assert++;
        if (beats != n_win * WN) begin n_fail++; $display("FAIL drain_timeout got %0d beats exp %0d", beats, n_win * WN); end
        @(negedge clk);
        n_assert++;
        if (o_win_count !== 8'd0 || exp_q.size() != 0 || o_win_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_end got cnt=%0d left=%0d vld=%b exp 0 0 0", o_win_count, exp_q.size(), o_win_valid);
        end
    endtask

    task automatic test_single();
        i_req = 4'b0100;
        @(negedge clk);
        for (int i = 0; i < WN; i++) begin
            n_assert++;
            if (o_grant !== 4'b0100 || o_fifo_wrreq !== 1'b1 || o_word_idx !== 8'(i) || o_fifo_data !== src_word(2, i)) begin
                n_fail++; $display("FAIL single_xfer i=%0d got g=%b wr=%b idx=%0d d=%h exp g=0100 wr=1 idx=%0d d=%h",
                                   i, o_grant, o_fifo_wrreq, o_word_idx, o_fifo_data, i, src_word(2, i));
            end
            exp_q.push_back(src_word(2, i));
            i_req = '0;  // dropping the request must not abort the window
            @(negedge clk);
        end
        n_assert++;
        if (o_win_count !== 8'd1 || o_fifo_wrreq !== 1'b0 || o_grant !== '0) begin
            n_fail++; $display("FAIL single_end got cnt=%0d wr=%b g=%b exp 1 0 0", o_win_count, o_fifo_wrreq, o_grant);
        end
    endtask

    task automatic test_read_overlap();
        logic [DW-1:0] e;
        i_compute_ready = 1'b1;
        @(negedge clk);
        i_compute_ready = 1'b0;  // ignored once the burst has started
        n_assert++;
        if (o_win_count !== 8'd0) begin n_fail++; $display("FAIL burst_dec got %0d exp 0", o_win_count); end
        for (int c = 0; c <= WN; c++) begin
            n_assert++;
            if (o_fifo_rdreq !== (c < WN) || o_win_valid !== (c >= 1) || o_win_last !== (c == WN)) begin
                n_fail++; $display("FAIL burst_timing c=%0d got rd=%b vld=%b last=%b exp %b %b %b",
                                   c, o_fifo_rdreq, o_win_valid, o_win_last, c < WN, c >= 1, c == WN);
            end
            if (o_win_valid === 1'b1) begin
                n_assert++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                if (o_win_data !== e) begin n_fail++; $display("FAIL burst_data c=%0d got %h exp %h", c, o_win_data, e); end
            end
            @(negedge clk);
        end
        // Two windows; the second ends on the very edge a burst starts.
        i_req = 4'b0001;
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < WN; i++) begin
                n_assert++;
                if (o_grant !== 4'(1 << w) || o_fifo_data !== src_word(w, i)) begin
                    n_fail++; $display("FAIL ovl_xfer w=%0d i=%0d got g=%b d=%h exp g=%b d=%h",
                                       w, i, o_grant, o_fifo_data, 4'(1 << w), src_word(w, i));
                end
                exp_q.push_back(src_word(w, i));
                if (w == 0 && i == 0) i_req = 4'b0010;
                if (w == 1 && i == WN - 1) begin i_compute_ready = 1'b1; i_req = '0; end
                @(negedge clk);
            end
            if (w == 0) @(negedge clk);
        end
        i_compute_ready = 1'b0;
        n_assert++;
        if (o_win_count !== 8'd1 || o_fifo_rdreq !== 1'b1) begin
            n_fail++; $display("FAIL ovl_count got cnt=%0d rd=%b exp 1 1", o_win_count, o_fifo_rdreq);
        end
        test_drain(2);
    endtask

    task automatic test_backpressure();
        ovr_en  = 1'b1;
        ovr_val = 10'd1011;
        i_req   = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_assert++;
            if (o_grant !== '0 || o_fifo_wrreq !== 1'b0) begin
                n_fail++; $display("FAIL bp_stall c=%0d got g=%b wr=%b exp 0 0", c, o_grant, o_fifo_wrreq);
            end
        end
        ovr_val = 10'd1010;
        @(negedge clk);
        i_req = '0;
        for (int i = 0; i < WN; i++) begin
            n_assert++;
            if (o_grant !== 4'b0010 || o_word_idx !== 8'(i) || o_fifo_data !== src_word(1, i)) begin
                n_fail++; $display("FAIL bp_xfer i=%0d got g=%b idx=%0d d=%h exp g=0010 idx=%0d d=%h",
                                   i, o_grant, o_word_idx, o_fifo_data, i, src_word(1, i));
            end
            @(negedge clk);
        end
        ovr_en = 1'b0;
        n_assert++;
        if (o_win_count !== 8'd1) begin n_fail++; $display("FAIL bp_count got %0d exp 1", o_win_count); end
    endtask

    task automatic test_mid_reset();
        i_req = 4'b1111;
        @(negedge clk);
        n_assert++;
        if (o_grant !== 4'b0100) begin n_fail++; $display("FAIL mr_grant got %b exp 0100", o_grant); end
        repeat (4) @(negedge clk);
        n_assert++;
        if (o_word_idx !== 8'd4) begin n_fail++; $display("FAIL mr_idx got %0d exp 4", o_word_idx); end
        rst_n = 1'b0;
        #1;
        n_assert++;
        if (o_grant !== '0 || o_fifo_wrreq !== 1'b0 || o_word_idx !== 8'd0 || o_fifo_sclr !== 1'b1 || o_win_count !== 8'd0) begin
            n_fail++; $display("FAIL mr_clear got g=%b wr=%b idx=%0d sclr=%b cnt=%0d exp 0 0 0 1 0",
                               o_grant, o_fifo_wrreq, o_word_idx, o_fifo_sclr, o_win_count);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_assert++;
        if (o_fifo_sclr !== 1'b0 || o_grant !== '0) begin
            n_fail++; $display("FAIL mr_flush got sclr=%b g=%b exp 0 0", o_fifo_sclr, o_grant);
        end
        @(negedge clk);
        i_req = '0;
        for (int i = 0; i < WN; i++) begin
            n_assert++;
            if (o_grant !== 4'b0001 || o_word_idx !== 8'(i) || o_fifo_data !== src_word(0, i)) begin
                n_fail++; $display("FAIL mr_restart i=%0d got g=%b idx=%0d d=%h exp g=0001 idx=%0d d=%h",
                                   i, o_grant, o_word_idx, o_fifo_data, i, src_word(0, i));
            end
            exp_q.push_back(src_word(0, i));
            @(negedge clk);
        end
        test_drain(1);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_drain(5);
        test_single();
        test_read_overlap();
        test_backpressure();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
